// File: rtl/fde_sequencer_pkg.sv
// Shared definitions for the fetch/decode/execute sequencer: state encoding,
// major-byte opcodes, top-nibble classes and decode enable-vector layout.
package fde_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_COMMIT  = 3'd3,
        ST_HALT    = 3'd4
    } state_t;

    // Major-byte opcodes that drive datapath enables during DECODE
    localparam logic [7:0] OP_ALU_RD      = 8'h22;
    localparam logic [7:0] OP_RAM_RD      = 8'h42;
    localparam logic [7:0] OP_RAM_WR      = 8'h41;
    localparam logic [7:0] OP_ROM_TO_RAM  = 8'h31;
    localparam logic [7:0] OP_RAM_TO_ALU  = 8'h92;
    localparam logic [7:0] OP_ALU_TO_RAM  = 8'h91;

    // Top-nibble instruction classes
    localparam logic [3:0] NIB_ALU     = 4'h1;  // visits EXECUTE, writes ALU
    localparam logic [3:0] NIB_JMP_RAM = 4'h7;  // COMMIT reads RAM, waits on memory
    localparam logic [3:0] NIB_RSVD    = 4'hF;  // legal no-operation class

    // Bit positions inside the decode enable vector
    localparam int EN_W      = 5;
    localparam int EN_ROM_RD = 0;
    localparam int EN_ALU_RD = 1;
    localparam int EN_ALU_WR = 2;
    localparam int EN_RAM_RD = 3;
    localparam int EN_RAM_WR = 4;

endpackage

// File: rtl/fde_sequencer_opdecode.sv
// Purely combinational instruction classifier: maps the top byte of the
// instruction register to DECODE-phase enables and instruction-class flags.
module fde_opdecode
    import fde_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0] ir,
    output logic [EN_W-1:0]       en,
    output logic                  is_alu,
    output logic                  is_jmp_ram,
    output logic                  is_halt,
    output logic                  is_illegal
);

    logic [7:0] major;
    logic [3:0] nibble;
    logic       in_table;

    assign major  = ir[DATA_WIDTH-1 -: 8];
    assign nibble = major[7:4];

    // Table lookup of the major byte; anything unlisted enables nothing
    always_comb begin
        en       = '0;
        in_table = 1'b1;
        case (major)
            OP_ALU_RD:     en[EN_ALU_RD] = 1'b1;
            OP_RAM_RD:     en[EN_RAM_RD] = 1'b1;
            OP_RAM_WR:     en[EN_RAM_WR] = 1'b1;
            OP_ROM_TO_RAM: begin
                en[EN_ROM_RD] = 1'b1;
                en[EN_RAM_WR] = 1'b1;
            end
            OP_RAM_TO_ALU: begin
                en[EN_RAM_RD] = 1'b1;
                en[EN_ALU_WR] = 1'b1;
            end
            OP_ALU_TO_RAM: begin
                en[EN_ALU_RD] = 1'b1;
                en[EN_RAM_WR] = 1'b1;
            end
            default:       in_table = 1'b0;
        endcase
    end

    assign is_halt    = (ir == '0);
    assign is_alu     = (nibble == NIB_ALU);
    assign is_jmp_ram = (nibble == NIB_JMP_RAM);
    // Only a non-zero word that matches neither the table nor a known class
    assign is_illegal = !is_halt && !in_table && (nibble != NIB_ALU) &&
                        (nibble != NIB_JMP_RAM) && (nibble != NIB_RSVD);

endmodule

// File: rtl/fde_sequencer.sv
// Fetch/decode/execute/commit control sequencer. Walks each instruction
// through its phases, stalls on memory handshakes, counts retired
// instructions and parks in HALT on an all-zero instruction word.
module fde_sequencer
    import fde_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 32,
    parameter int SKIP_IDLE  = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  run,
    input  logic                  step,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] opcode,
    output logic                  pc_read_en,
    output logic                  rom_en,
    output logic                  rom_read_data_en,
    output logic                  alu_read_en,
    output logic                  alu_write_en,
    output logic                  ram_read_en,
    output logic                  ram_write_en,
    output logic                  pc_en,
    output logic [2:0]            state,
    output logic                  halted,
    output logic                  illegal_op,
    output logic [CNT_WIDTH-1:0]  instr_count
);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] ir_q;
    logic [CNT_WIDTH-1:0]  instr_count_q;
    logic                  step_pending_q;
    logic                  illegal_q;
    logic                  halted_q;

    logic [EN_W-1:0]       dec_en;
    logic                  dec_alu, dec_jmp_ram, dec_halt, dec_illegal;
    logic                  dec_ram_wait;
    logic                  armed;
    logic                  fetch_take;
    logic                  commit_done;

    logic pc_read_c, rom_c, rom_rd_c, alu_rd_c, alu_wr_c, ram_rd_c, ram_wr_c, pc_en_c;

    fde_opdecode #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_opdecode (
        .ir         (ir_q),
        .en         (dec_en),
        .is_alu     (dec_alu),
        .is_jmp_ram (dec_jmp_ram),
        .is_halt    (dec_halt),
        .is_illegal (dec_illegal)
    );

    assign armed        = run | step_pending_q;
    assign dec_ram_wait = dec_en[EN_RAM_RD] | dec_en[EN_RAM_WR];
    assign fetch_take   = (state_q == ST_FETCH) && armed && mem_ready;
    assign commit_done  = (state_q == ST_COMMIT) && (!dec_jmp_ram || mem_ready);

    // State register plus the registered status/bookkeeping outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_FETCH;
            ir_q           <= '0;
            instr_count_q  <= '0;
            step_pending_q <= 1'b0;
            illegal_q      <= 1'b0;
            halted_q       <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= (state_d == ST_HALT);
            if (fetch_take) begin
                ir_q <= opcode;
            end
            // A fetch consumes the pending step; further steps collapse into one
            if (fetch_take) begin
                step_pending_q <= 1'b0;
            end else if (step && (state_q != ST_HALT)) begin
                step_pending_q <= 1'b1;
            end
            if ((state_q == ST_DECODE) && dec_illegal) begin
                illegal_q <= 1'b1;
            end
            if (commit_done && (instr_count_q != {CNT_WIDTH{1'b1}})) begin
                instr_count_q <= instr_count_q + CNT_WIDTH'(1);
            end
        end
    end

    // Next-state selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                if (fetch_take) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (dec_halt) begin
                    state_d = ST_HALT;
                end else if (!dec_ram_wait || mem_ready) begin
                    state_d = (dec_alu || (SKIP_IDLE == 0)) ? ST_EXECUTE : ST_COMMIT;
                end
            end
            ST_EXECUTE: state_d = ST_COMMIT;
            ST_COMMIT: begin
                if (commit_done) begin
                    state_d = ST_FETCH;
                end
            end
            ST_HALT:    state_d = ST_HALT;
            default:    state_d = ST_FETCH;
        endcase
    end

    // Datapath enables decoded from the current phase and instruction
    always_comb begin
        pc_read_c = 1'b0;
        rom_c     = 1'b0;
        rom_rd_c  = 1'b0;
        alu_rd_c  = 1'b0;
        alu_wr_c  = 1'b0;
        ram_rd_c  = 1'b0;
        ram_wr_c  = 1'b0;
        pc_en_c   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                pc_read_c = armed;
                rom_c     = armed;
            end
            ST_DECODE: begin
                rom_rd_c = dec_en[EN_ROM_RD];
                alu_rd_c = dec_en[EN_ALU_RD];
                alu_wr_c = dec_en[EN_ALU_WR];
                ram_rd_c = dec_en[EN_RAM_RD];
                ram_wr_c = dec_en[EN_RAM_WR];
            end
            ST_EXECUTE: alu_wr_c = dec_alu;
            ST_COMMIT: begin
                pc_en_c  = 1'b1;
                ram_rd_c = dec_jmp_ram;
            end
            default: ;
        endcase
    end

    // Reset must silence the enables immediately, even with run held high
    assign pc_read_en       = reset_n & pc_read_c;
    assign rom_en           = reset_n & rom_c;
    assign rom_read_data_en = reset_n & rom_rd_c;
    assign alu_read_en      = reset_n & alu_rd_c;
    assign alu_write_en     = reset_n & alu_wr_c;
    assign ram_read_en      = reset_n & ram_rd_c;
    assign ram_write_en     = reset_n & ram_wr_c;
    assign pc_en            = reset_n & pc_en_c;

    assign state       = state_q;
    assign halted      = halted_q;
    assign illegal_op  = illegal_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_fde_sequencer.sv
// Randomised bench for fde_sequencer with an instruction-level reference
// model: each fetched instruction expands into a queue of expected phases.
module tb_fde_sequencer;

    localparam int CNT_W = 4;
    localparam int MAXC  = (1 << CNT_W) - 1;

    // Enable vector layout {pc_read, rom, rom_rd_data, alu_rd, alu_wr, ram_rd, ram_wr, pc_en}
    localparam logic [7:0] B_PCRD  = 8'h80;
    localparam logic [7:0] B_ROM   = 8'h40;
    localparam logic [7:0] B_ROMD  = 8'h20;
    localparam logic [7:0] B_ALURD = 8'h10;
    localparam logic [7:0] B_ALUWR = 8'h08;
    localparam logic [7:0] B_RAMRD = 8'h04;
    localparam logic [7:0] B_RAMWR = 8'h02;
    localparam logic [7:0] B_PCEN  = 8'h01;

    logic             clk;
    logic             reset_n;
    logic             run, step, mem_ready;
    logic [15:0]      opcode;
    logic             pc_read_en, rom_en, rom_read_data_en, alu_read_en;
    logic             alu_write_en, ram_read_en, ram_write_en, pc_en;
    logic [2:0]       state;
    logic             halted, illegal_op;
    logic [CNT_W-1:0] instr_count;
    logic [7:0]       en_vec;

    int n_total = 0;
    int n_bad   = 0;

    fde_sequencer #(
        .DATA_WIDTH (16),
        .CNT_WIDTH  (CNT_W),
        .SKIP_IDLE  (1)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .run              (run),
        .step             (step),
        .mem_ready        (mem_ready),
        .opcode           (opcode),
        .pc_read_en       (pc_read_en),
        .rom_en           (rom_en),
        .rom_read_data_en (rom_read_data_en),
        .alu_read_en      (alu_read_en),
        .alu_write_en     (alu_write_en),
        .ram_read_en      (ram_read_en),
        .ram_write_en     (ram_write_en),
        .pc_en            (pc_en),
        .state            (state),
        .halted           (halted),
        .illegal_op       (illegal_op),
        .instr_count      (instr_count)
    );

    assign en_vec = {pc_read_en, rom_en, rom_read_data_en, alu_read_en,
                     alu_write_en, ram_read_en, ram_write_en, pc_en};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [2:0] st;    // state the DUT must show during this phase
        logic [7:0] en;    // enables it must drive
        logic       wt;    // phase waits for mem_ready
        logic       halt;  // leaving this phase enters HALT
        logic       ill;   // leaving this phase flags illegal_op
        logic       cmt;   // leaving this phase retires the instruction
    } ph_t;

    ph_t  m_q[$];
    logic m_pending, m_halted, m_illegal;
    int   m_count;

    task automatic model_reset();
        m_q.delete();
        m_pending = 1'b0;
        m_halted  = 1'b0;
        m_illegal = 1'b0;
        m_count   = 0;
    endtask

    task automatic model_build(input logic [15:0] op);
        logic [7:0] top;
        logic [3:0] nib;
        logic [7:0] den;
        logic       known;
        ph_t        p;
        top   = op[15:8];
        nib   = op[15:12];
        known = 1'b1;
        case (top)
            8'h22:   den = B_ALURD;
            8'h42:   den = B_RAMRD;
            8'h41:   den = B_RAMWR;
            8'h31:   den = B_ROMD | B_RAMWR;
            8'h92:   den = B_RAMRD | B_ALUWR;
            8'h91:   den = B_ALURD | B_RAMWR;
            default: begin den = 8'h00; known = 1'b0; end
        endcase
        p.st   = 3'd1;
        p.en   = den;
        p.wt   = (den & (B_RAMRD | B_RAMWR)) != 0;
        p.halt = (op == 16'h0000);
        p.ill  = (op != 16'h0000) && !known && nib != 4'h1 && nib != 4'h7 && nib != 4'hF;
        p.cmt  = 1'b0;
        m_q.push_back(p);
        if (op != 16'h0000) begin
            if (nib == 4'h1) begin
                p.st = 3'd2; p.en = B_ALUWR; p.wt = 1'b0; p.ill = 1'b0; p.halt = 1'b0;
                m_q.push_back(p);
            end
            p.st   = 3'd3;
            p.en   = B_PCEN | ((nib == 4'h7) ? B_RAMRD : 8'h00);
            p.wt   = (nib == 4'h7);
            p.ill  = 1'b0;
            p.halt = 1'b0;
            p.cmt  = 1'b1;
            m_q.push_back(p);
        end
    endtask

    function automatic logic [2:0] exp_state();
        if (m_halted) return 3'd4;
        if (m_q.size() == 0) return 3'd0;
        return m_q[0].st;
    endfunction

    function automatic logic [7:0] exp_en();
        if (m_halted) return 8'h00;
        if (m_q.size() == 0) return (run || m_pending) ? (B_PCRD | B_ROM) : 8'h00;
        return m_q[0].en;
    endfunction

    // Advance the model across one rising edge using this cycle's inputs
    task automatic model_advance();
        ph_t p;
        if (m_halted) return;
        if (m_q.size() == 0) begin
            if ((run || m_pending) && mem_ready) begin
                model_build(opcode);
                m_pending = 1'b0;
            end else if (step) begin
                m_pending = 1'b1;
            end
        end else begin
            if (step) m_pending = 1'b1;
            if (!m_q[0].wt || mem_ready) begin
                p = m_q.pop_front();
                if (p.ill) m_illegal = 1'b1;
                if (p.halt) begin
                    m_halted = 1'b1;
                    m_q.delete();
                end
                if (p.cmt && m_count < MAXC) m_count++;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        check_eq("state",   32'(state),       32'(exp_state()));
        check_eq("enables", 32'(en_vec),      32'(exp_en()));
        check_eq("halted",  32'(halted),      32'(m_halted));
        check_eq("illegal", 32'(illegal_op),  32'(m_illegal));
        check_eq("count",   32'(instr_count), 32'(m_count));
    endtask

    // One clock: drive inputs just after the rising edge, check at the falling edge
    task automatic do_cycle(input logic r, input logic s, input logic mr, input logic [15:0] op);
        run       = r;
        step      = s;
        mem_ready = mr;
        opcode    = op;
        @(negedge clk);
        compare_all();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset asserted between edges, then released while idle
    task automatic apply_reset();
        reset_n = 1'b0;
        #1;
        check_eq("rst_state",   32'(state),       32'd0);
        check_eq("rst_enables", 32'(en_vec),      32'd0);
        check_eq("rst_count",   32'(instr_count), 32'd0);
        check_eq("rst_halted",  32'(halted),      32'd0);
        check_eq("rst_illegal", 32'(illegal_op),  32'd0);
        model_reset();
        run  = 1'b0;
        step = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rand_op();
        logic [7:0] tops [10];
        int         k;
        logic [7:0] t;
        tops = '{8'h22, 8'h42, 8'h41, 8'h31, 8'h92, 8'h91, 8'h1A, 8'h7C, 8'hF3, 8'h55};
        k = $urandom_range(0, 11);
        if (k < 10)       t = tops[k];
        else if (k == 10) t = 8'($urandom_range(0, 255));
        else              t = 8'h00;
        if (t == 8'h00 && $urandom_range(0, 3) != 0) return 16'h0000;
        return {t, 8'($urandom_range(0, 255))};
    endfunction

    initial begin
        reset_n   = 1'b0;
        run       = 1'b1;
        step      = 1'b0;
        mem_ready = 1'b1;
        opcode    = 16'h0000;
        model_reset();
        @(posedge clk);
        #1;
        apply_reset();

        // ALU instruction walks FETCH, DECODE, EXECUTE, COMMIT
        check_eq("s34_st0", 32'(state), 32'd0);
        do_cycle(1, 0, 1, 16'h1234);
        check_eq("s34_st1", 32'(state), 32'd1);
        do_cycle(1, 0, 1, 16'h1234);
        check_eq("s34_st2", 32'(state), 32'd2);
        check_eq("s34_aluwr", 32'(alu_write_en), 32'd1);
        do_cycle(1, 0, 1, 16'h1234);
        check_eq("s34_st3", 32'(state), 32'd3);
        check_eq("s34_aluwr_c", 32'(alu_write_en), 32'd0);
        do_cycle(1, 0, 1, 16'h1234);
        check_eq("s34_st4", 32'(state), 32'd0);
        check_eq("s34_cnt", 32'(instr_count), 32'd1);
        do_cycle(0, 0, 1, 16'h0000);

        // RAM read stalls in DECODE for three cycles, EXECUTE skipped
        apply_reset();
        do_cycle(1, 0, 1, 16'h4200);
        for (int i = 0; i < 3; i++) begin
            check_eq("s35_dec_st", 32'(state), 32'd1);
            check_eq("s35_ramrd", 32'(ram_read_en), 32'd1);
            do_cycle(0, 0, 0, 16'h4200);
        end
        check_eq("s35_dec_st", 32'(state), 32'd1);
        do_cycle(0, 0, 1, 16'h4200);
        check_eq("s35_commit", 32'(state), 32'd3);
        do_cycle(0, 0, 1, 16'h4200);

        // Single step retires exactly one instruction
        apply_reset();
        do_cycle(0, 1, 1, 16'h9100);
        for (int i = 0; i < 8; i++) do_cycle(0, 0, 1, 16'h9100);
        check_eq("s36_cnt", 32'(instr_count), 32'd1);
        check_eq("s36_st", 32'(state), 32'd0);
        check_eq("s36_en", 32'(en_vec), 32'd0);

        // Illegal opcode runs as a NOP and the flag is sticky
        apply_reset();
        do_cycle(1, 0, 1, 16'h5500);
        do_cycle(1, 0, 1, 16'h5500);
        check_eq("s38_pcen", 32'(pc_en), 32'd1);
        do_cycle(0, 0, 1, 16'h5500);
        check_eq("s38_ill", 32'(illegal_op), 32'd1);
        check_eq("s38_cnt", 32'(instr_count), 32'd1);
        for (int i = 0; i < 4; i++) do_cycle(1, 0, 1, 16'h2200);
        check_eq("s38_sticky", 32'(illegal_op), 32'd1);
        do_cycle(0, 0, 1, 16'h0000);

        // Reset mid-EXECUTE clears everything without a clock edge
        apply_reset();
        do_cycle(1, 0, 1, 16'h1234);
        do_cycle(1, 0, 1, 16'h1234);
        check_eq("s39_exec", 32'(state), 32'd2);
        apply_reset();

        // All-zero instruction halts; run and step are ignored afterwards
        do_cycle(1, 0, 1, 16'h0000);
        do_cycle(1, 0, 1, 16'h0000);
        check_eq("s37_halted", 32'(halted), 32'd1);
        for (int i = 0; i < 8; i++) do_cycle(i[0], i[1], 1, 16'h2200);
        check_eq("s37_state", 32'(state), 32'd4);
        apply_reset();

        // Randomised traffic against the model, including counter saturation
        for (int i = 0; i < 2000; i++) begin
            if (m_halted && $urandom_range(0, 5) == 0) begin
                apply_reset();
            end else if ($urandom_range(0, 399) == 0) begin
                apply_reset();
            end else begin
                do_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                         $urandom_range(0, 3) != 0, rand_op());
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
